// File: rtl/sti_pkg.sv
// Shared STI definitions: length codes, length-to-bit-count mapping and the
// per-word configuration record latched by the receiver.
package sti_pkg;

    typedef enum logic [1:0] {
        LEN8  = 2'b00,
        LEN16 = 2'b01,
        LEN24 = 2'b10,
        LEN32 = 2'b11
    } sti_len_e;

    typedef struct packed {
        sti_len_e length;
        logic     fill;
        logic     msb;
        logic     low;
    } sti_cfg_t;

    function automatic logic [5:0] len_bits(input sti_len_e l);
        return {1'b0, l, 3'b000} + 6'd8;
    endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// Combinational word extraction from the receive shift register.
// Padding-error output exists only when STI_RX_CHECK_EN is defined.
module sti_rx_extract
    import sti_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned MAXBITS = 32
) (
    input  logic [MAXBITS-1:0] sr_i,
    input  sti_len_e           length_i,
    input  logic               fill_i,
    input  logic               low_i,
`ifdef STI_RX_CHECK_EN
    output logic               pad_err_o,
`endif
    output logic [DW-1:0]      word_o
);

    logic [31:0]        lb;
    logic [MAXBITS-1:0] shifted;

    assign lb = {26'd0, len_bits(length_i)};

    always_comb begin
        word_o  = '0;
        shifted = sr_i;
        case (length_i)
            LEN8:    word_o = low_i ? {{(DW-8){1'b0}}, sr_i[7:0]} : {sr_i[7:0], {(DW-8){1'b0}}};
            LEN16:   word_o = sr_i[DW-1:0];
            default: begin
                // MSB-filled words sit at the top of the L-bit field
                if (fill_i) shifted = sr_i >> (lb - DW);
                word_o = shifted[DW-1:0];
            end
        endcase
    end

`ifdef STI_RX_CHECK_EN
    always_comb begin
        pad_err_o = 1'b0;
        for (int unsigned i = 0; i < MAXBITS; i++) begin
            if (lb > DW && sr_i[i] &&
                (fill_i ? (i < lb - DW) : (i >= DW && i < lb)))
                pad_err_o = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver with one-entry valid/ready output register.
// Define STI_RX_CHECK_EN to enable framing checks on rx_err.
module sti_rx
    import sti_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned MAXBITS = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          so_data,
    input  logic          so_valid,
    input  logic [1:0]    pi_length,
    input  logic          pi_fill,
    input  logic          pi_msb,
    input  logic          pi_low,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          rx_ovf,
    output logic          rx_err
);

    localparam int unsigned AW = $clog2(MAXBITS);

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e             state_q, state_d;
    sti_cfg_t           cfg_q, cfg_d;
    logic [MAXBITS-1:0] sr_q, sr_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [DW-1:0]      data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [DW-1:0]      word;
`ifdef STI_RX_CHECK_EN
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;
    logic               pad_err;
`endif

    sti_rx_extract #(.DW(DW), .MAXBITS(MAXBITS)) u_extract (
        .sr_i     (sr_q),
        .length_i (cfg_q.length),
        .fill_i   (cfg_q.fill),
        .low_i    (cfg_q.low),
`ifdef STI_RX_CHECK_EN
        .pad_err_o(pad_err),
`endif
        .word_o   (word)
    );

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
`ifdef STI_RX_CHECK_EN
        ovl_d   = ovl_q;
        err_d   = 1'b0;
`endif
        if (valid_q && rx_ready) valid_d = 1'b0;
        case (state_q)
            S_IDLE: if (so_valid) begin
                state_d = S_SHIFT;
                cfg_d   = '{length: sti_len_e'(pi_length), fill: pi_fill, msb: pi_msb, low: pi_low};
                sr_d    = {{(MAXBITS-1){1'b0}}, so_data};
                cnt_d   = 6'd1;
            end
            S_SHIFT: if (so_valid) begin
                if (cnt_q < 6'(MAXBITS)) begin
                    if (cfg_q.msb) sr_d = {sr_q[MAXBITS-2:0], so_data};
                    else           sr_d[cnt_q[AW-1:0]] = so_data;
                    cnt_d = cnt_q + 6'd1;
                end
`ifdef STI_RX_CHECK_EN
                else ovl_d = 1'b1;
`endif
            end else begin
                state_d = S_IDLE;
                sr_d    = '0;
                cnt_d   = '0;
                // A full register is freed by a same-cycle transfer
                if (!valid_q || rx_ready) begin
                    data_d  = word;
                    valid_d = 1'b1;
                end else begin
                    ovf_d   = 1'b1;
                end
`ifdef STI_RX_CHECK_EN
                err_d = (cnt_q != len_bits(cfg_q.length)) || ovl_q || pad_err;
                ovl_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef STI_RX_CHECK_EN
            ovl_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef STI_RX_CHECK_EN
            ovl_q   <= ovl_d;
            err_q   <= err_d;
`endif
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ovf   = ovf_q;
`ifdef STI_RX_CHECK_EN
    assign rx_err   = err_q;
`else
    assign rx_err   = 1'b0;
`endif

endmodule

// File: doc/sti_rx.md
# sti_rx

Serial-to-parallel receiver for the STI serial stream (`so_data`/`so_valid`). Each contiguous `so_valid` burst is one word. The block reassembles it using the same length, fill, bit-order and byte-select controls the transmitter used, and returns the original 16-bit parallel word. The word is delivered through a one-entry valid/ready output register. It sits on the far side of the STI link and is the loop-back checker for the transmitter in system benches.

## Interface
Parameters:
- `DW`, 16: recovered parallel word width.
- `MAXBITS`, 32: longest serial word, in bits.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `so_data`, in, 1: serial data bit.
- `so_valid`, in, 1: high for every bit of a word; low between words.
- `pi_length`, in, 2: serial length code. 00 = 8, 01 = 16, 10 = 24, 11 = 32 bits.
- `pi_fill`, in, 1: for 24/32-bit words, 1 = data in the MSBs (zero-padded below), 0 = data in the LSBs.
- `pi_msb`, in, 1: 1 = MSB transmitted first; 0 = LSB first.
- `pi_low`, in, 1: for 8-bit words, 1 = byte belongs in `rx_data[7:0]`, 0 = in `rx_data[15:8]`.
- `rx_data`, out, DW: recovered word.
- `rx_valid`, out, 1: `rx_data` holds a word.
- `rx_ready`, in, 1: consumer accepts the word.
- `rx_ovf`, out, 1: one-cycle pulse when a completed word is dropped.
- `rx_err`, out, 1: one-cycle pulse with a word whose framing is bad (see Configuration).

## Operation
States:
- IDLE, go to SHIFT: first cycle with `so_valid`=1. The first bit is sampled. `pi_length`, `pi_fill`, `pi_msb` and `pi_low` are latched into a config register and held for the whole word.
- SHIFT, stay: each cycle with `so_valid`=1 samples one bit.
  - `pi_msb`=1: shift left, new bit enters bit 0.
  - `pi_msb`=0: insert at position `bit_cnt`.
  - `bit_cnt` (6 bits) increments.
  - At `MAXBITS`, further bits are ignored and an overlength flag is set.
- SHIFT, go to IDLE: first cycle with `so_valid`=0. The word completes. The extraction below is applied to the `MAXBITS`-bit shift register.

Extraction, using latched config and L = 8/16/24/32:
- L=8: `pi_low`=1 gives {8'h00, sr[7:0]}; `pi_low`=0 gives {sr[7:0], 8'h00}.
- L=16: sr[15:0].
- L=24/32, `pi_fill`=1: sr[L-1:L-16].
- L=24/32, `pi_fill`=0: sr[15:0].

Output register behaviour at word completion:
- Empty, or full with `rx_ready`=1 in the same cycle: load the word and set `rx_valid`.
- Full with `rx_ready`=0: keep the old word and pulse `rx_ovf`.

Handshake:
- A transfer happens on a cycle with `rx_valid`=1 and `rx_ready`=1.
- `rx_valid` drops after the transfer unless a new word loads in that same cycle.
- `rx_data` stays stable while `rx_valid`=1 and the word has not been accepted.

Other rules:
- A new burst may start the cycle after completion. The shift register and `bit_cnt` clear on completion.
- A burst of 0 bits does not exist, because IDLE is left only on `so_valid`=1.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_ovf`=0, `rx_err`=0, state IDLE, `bit_cnt`=0, shift register 0, config register 0.
- Reset mid-word discards the partial word. After reset release, the next `so_valid` rise starts a fresh word.
- Latency: last bit sampled on edge N, `so_valid`=0 at edge N+1, `rx_valid` high after edge N+1. That is one cycle from the last bit.
- `rx_err` and `rx_ovf` are registered pulses, asserted in the cycle after the completion edge and for that cycle only.
- Throughput: one bit per cycle plus one idle cycle per word.

## Configuration
- `STI_RX_CHECK_EN` defined: on completion, `rx_err` pulses if either condition holds:
  - `bit_cnt` ≠ L, including overlength.
  - For L=24/32, any padding bit is nonzero.
- The word is still delivered when `rx_err` pulses.
- `STI_RX_CHECK_EN` undefined: `rx_err` is tied to 0 and the padding-compare logic is absent.

## Structure
- The shared package `sti_pkg` holds:
  - length-code constants `LEN8`/`LEN16`/`LEN24`/`LEN32`;
  - the function mapping a length code to its bit count;
  - the typedef for the latched config struct {length, fill, msb, low}.
- One sub-module, `sti_rx_extract`: combinational extraction from the shift register and config to the `DW`-bit word plus the padding-error flag.

## Test plan
- 16-bit MSB-first word 16'hA5C3, `rx_ready`=1: `rx_data`=16'hA5C3, `rx_valid` high for 1 cycle, 1 cycle after the last bit.
- 8-bit LSB-first byte 8'h3C, sent as 00111100 (bit 0 first):
  - `pi_low`=1: 16'h003C.
  - `pi_low`=0: 16'h3C00.
- 32-bit MSB-first {16'h1234, 16'h0000}, `pi_fill`=1: 16'h1234, `rx_err`=0. Resend with padding 16'h0001: 16'h1234 and `rx_err` pulse when `STI_RX_CHECK_EN` is defined.
- Two back-to-back 24-bit words with `rx_ready` held 0: the first word stays stable, `rx_ovf` pulses once, and the first word transfers when `rx_ready`=1.
- `reset` asserted after 10 bits of a 16-bit word, then a full word 16'hBEEF: only 16'hBEEF is delivered and there is no `rx_err`.
- A 20-bit burst with `pi_length`=01: `rx_err` pulses with `STI_RX_CHECK_EN` defined and stays 0 when it is undefined.
